ddr_rd_capture_ctrl: RTL and testbench
======================================

// Module: ddr_rd_capture_ctrl
// PURPOSE
//  Sequences the x8 DDR input-capture datapath for DRAM read bursts. It tracks
//  each issued read through a programmable read latency and opens a BL8
//  capture window of 4 clk beats. In each beat it takes one (d0,d1) byte pair
//  from the iddr stage and assembles the burst into a 64-bit word.
//  Sits between the command scheduler (rd_issue) and the read-return path.
// PARAMETERS
//  DW      8   byte-lane width; d0/d1 are DW bits wide
//  BEATS   4   clk beats per burst (BL8 / 2); burst word = 2*BEATS*DW bits
//  RL_MAX  31  max supported read latency in clk; sets delay-line depth
// PORTS
//  clk        in   1        system clock; same clock as the iddr stage
//  rst_n      in   1        asynchronous, active-low reset
//  cfg_rl     in   5        read latency: clk cycles from rd_issue to first beat
//  rd_issue   in   1        1-cycle pulse: read command sent to DRAM this cycle
//  d0         in   DW       iddr rising-edge byte (earlier in time)
//  d1         in   DW       iddr falling-edge byte (later in time)
//  rd_data    out  2*BEATS*DW  assembled burst; byte0 in [DW-1:0]
//  rd_valid   out  1        1-cycle pulse: rd_data holds a complete burst
//  rd_err     out  1        1-cycle pulse: a burst collided and was dropped
//  busy       out  1        one or more reads outstanding
// BEHAVIOUR
//  Reset (async, rst_n=0): delay line, beat counter, pending count and rl_q
//   are cleared; rl_q resets to 1. rd_data=0, rd_valid=0, rd_err=0, busy=0.
//   A reset mid-burst discards the burst. No rd_valid is produced for any
//   read issued before reset.
//  Latency config:
//   - rl_q <= cfg_rl on every edge where pending==0. It is frozen otherwise.
//   - An rd_issue in a cycle with pending==0 uses the new cfg_rl.
//   - cfg_rl of 0 is treated as 1. Values above RL_MAX clamp to RL_MAX.
//  Delay line: sr[0]<=rd_issue; sr[k]<=sr[k-1] on every edge.
//   - Burst start in cycle T+rl_q (T = the cycle rd_issue is high) is
//     sr[rl_q-1].
//  FSM IDLE/CAPTURE, beat counter bc in 0..BEATS-1:
//   - IDLE: start -> CAPTURE, bc=0.
//   - CAPTURE: on each edge write d0 to byte 2*bc and d1 to byte 2*bc+1 of the
//     shadow word, then bc++.
//   - After the edge that captures bc=BEATS-1, load the shadow word into
//     rd_data and pulse rd_valid in the next cycle (T+rl_q+BEATS).
//   - If start coincides with bc=BEATS-1, go straight to a new burst with
//     bc=0. This is the seamless back-to-back case: no gap and no error.
//   - If start arrives while bc<BEATS-1, the new read is dropped. rd_err
//     pulses in the next cycle. The current burst completes normally.
//   - Back at IDLE when bc=BEATS-1 completes with no new start.
//  rd_data holds its value between rd_valid pulses.
//  pending counter (6b): +1 on rd_issue, -1 on each completion or drop.
//   - Simultaneous issue and completion leaves pending unchanged.
//   - busy = (pending!=0). The counter saturates and never wraps.
//  Throughput: one burst per BEATS cycles max. rd_issue closer than BEATS
//   cycles apart is a scheduler error, flagged through rd_err.
// TESTING
//  - Reset: rst_n=0 mid-burst -> outputs 0 at once. No rd_valid after release.
//  - cfg_rl=6, rd_issue@T=10, d0/d1 = 00/01,02/03,04/05,06/07 in cycles 16-19
//    -> rd_valid@20, rd_data=64'h0706050403020100.
//  - rd_issue@10 and @14, cfg_rl=6 -> rd_valid@20 and @24, busy high 11..24,
//    rd_err never asserted.
//  - rd_issue@10 and @12, cfg_rl=6 -> first burst valid@20, rd_err@19,
//    only one rd_valid, pending returns to 0.
//  - cfg_rl changed 6->9 while busy -> current read still uses 6. After busy
//    drops, a new read with rd_issue@50 gives rd_valid@63.
//  - cfg_rl=0 and cfg_rl=1, rd_issue@5 -> first beat in cycle 6,
//    rd_valid@10, in both cases.

Source files
------------

// File: rtl/ddr_rd_capture_ctrl_if.sv
// Bus between the command scheduler / iddr stage and the DDR read capture sequencer.
interface ddr_rd_capture_ctrl_if #(
  parameter int DW    = 8,
  parameter int BEATS = 4
);
  logic [4:0]            cfg_rl;
  logic                  rd_issue;
  logic [DW-1:0]         d0;
  logic [DW-1:0]         d1;
  logic [2*BEATS*DW-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  busy;

  modport master (output cfg_rl, rd_issue, d0, d1,
                  input  rd_data, rd_valid, rd_err, busy);
  modport slave  (input  cfg_rl, rd_issue, d0, d1,
                  output rd_data, rd_valid, rd_err, busy);
endinterface

// File: rtl/ddr_rd_capture_ctrl.sv
// Tracks reads through a programmable latency and assembles each BL8 burst
// (BEATS clk beats of d0/d1 byte pairs) into one wide word.
module ddr_rd_capture_ctrl #(
  parameter int DW     = 8,
  parameter int BEATS  = 4,
  parameter int RL_MAX = 31
) (
  input logic                  clk,
  input logic                  rst_n,
  ddr_rd_capture_ctrl_if.slave bus
);
  localparam int RLW = $clog2(RL_MAX + 1);
  localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                          state;
  logic [BW-1:0]                   bc;
  logic [RL_MAX-1:0]               sr;
  logic [RLW-1:0]                  rl_q, rl_eff;
  logic [5:0]                      pending, pending_nxt;
  logic [2*BEATS-1:0][DW-1:0]      shadow, nxt;
  logic                            start, free, cap_en, done, drop;
  logic [BW-1:0]                   cap_idx;

  always_comb begin
    int cr;
    cr = int'(bus.cfg_rl);
    if (cr < 1)           cr = 1;
    else if (cr > RL_MAX) cr = RL_MAX;
    rl_eff = RLW'(cr);
  end

  assign start = sr[rl_q - 1'b1];
  // bc is the beat captured on the previous edge; a new burst may only
  // begin once the final beat of the current one has been taken.
  assign free  = (state == IDLE) || (bc == LAST);

  always_comb begin
    cap_en  = 1'b0;
    cap_idx = '0;
    drop    = 1'b0;
    if (start && free) begin
      cap_en = 1'b1;
    end else if (state == CAPTURE && bc != LAST) begin
      cap_en  = 1'b1;
      cap_idx = bc + 1'b1;
      drop    = start;
    end
    done = cap_en && (cap_idx == LAST);
    nxt  = shadow;
    if (cap_en) begin
      nxt[{cap_idx, 1'b0}] = bus.d0;
      nxt[{cap_idx, 1'b1}] = bus.d1;
    end
  end

  // Retirement is counted when rd_valid/rd_err are seen, so busy covers the
  // cycle in which the result is presented.
  always_comb begin
    int pn;
    pn = int'(pending) + int'(bus.rd_issue) - int'(bus.rd_valid) - int'(bus.rd_err);
    if (pn < 0)       pn = 0;
    else if (pn > 63) pn = 63;
    pending_nxt = 6'(pn);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bc           <= '0;
      sr           <= '0;
      rl_q         <= RLW'(1);
      pending      <= '0;
      shadow       <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_err   <= 1'b0;
    end else begin
      sr      <= {sr[RL_MAX-2:0], bus.rd_issue};
      pending <= pending_nxt;
      if (pending == '0) rl_q <= rl_eff;
      state <= cap_en ? CAPTURE : IDLE;
      if (cap_en) bc <= cap_idx;
      shadow       <= nxt;
      bus.rd_valid <= done;
      bus.rd_err   <= drop;
      if (done) bus.rd_data <= nxt;
    end
  end

  assign bus.busy = (pending != '0);
endmodule

// File: tb/tb_ddr_rd_capture_ctrl.sv
// Directed bench for ddr_rd_capture_ctrl: latency, back-to-back, collision, config freeze, reset.
module tb_ddr_rd_capture_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ddr_rd_capture_ctrl_if #(.DW(8), .BEATS(4)) bus ();
  ddr_rd_capture_ctrl #(.DW(8), .BEATS(4), .RL_MAX(31)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_err = 0;
  int cyc;
  int ia, ib, cfg_a, cfg_b, cfg_chg;
  int v_cyc[$];
  logic [63:0] v_dat[$];
  int e_cyc[$];
  bit busy_at[0:127];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // d0/d1 follow a cycle-indexed ramp so every burst has a known content
  task automatic drive();
    bus.rd_issue = (cyc == ia) || (cyc == ib);
    bus.cfg_rl   = 5'((cfg_chg >= 0 && cyc >= cfg_chg) ? cfg_b : cfg_a);
    bus.d0       = 8'(2 * (cyc - 16));
    bus.d1       = 8'(2 * (cyc - 16) + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    if (bus.rd_valid) begin v_cyc.push_back(cyc); v_dat.push_back(bus.rd_data); end
    if (bus.rd_err) e_cyc.push_back(cyc);
    if (cyc < 128) busy_at[cyc] = bus.busy;
  endtask

  task automatic start_test(input int ca, input int cb, input int cc, input int a, input int b, input int n);
    cfg_a = ca; cfg_b = cb; cfg_chg = cc; ia = a; ib = b;
    rst_n = 1'b0;
    cyc = 0;
    bus.rd_issue = 1'b0; bus.cfg_rl = 5'(ca); bus.d0 = '0; bus.d1 = '0;
    v_cyc.delete(); v_dat.delete(); e_cyc.delete();
    for (int i = 0; i < 128; i++) busy_at[i] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (n) tick();
  endtask

  function automatic int vc(input int i);
    return (v_cyc.size() > i) ? v_cyc[i] : -1;
  endfunction
  function automatic logic [63:0] vd(input int i);
    return (v_dat.size() > i) ? v_dat[i] : 64'hDEAD;
  endfunction

  initial begin
    bit all_busy;
    rst_n = 1'b0;
    cyc = 0; ia = -1; ib = -1; cfg_a = 6; cfg_b = 6; cfg_chg = -1;
    bus.rd_issue = 1'b0; bus.cfg_rl = 5'd6; bus.d0 = '0; bus.d1 = '0;
    #1;
    chk("rst_data",  bus.rd_data,  64'h0);
    chk("rst_valid", bus.rd_valid, 64'h0);
    chk("rst_err",   bus.rd_err,   64'h0);
    chk("rst_busy",  bus.busy,     64'h0);

    // single read rl=6 @10, second read @40 cut by reset mid-burst
    start_test(6, 6, -1, 10, 40, 47);
    chk("t1_nvalid", v_cyc.size(), 1);
    chk("t1_vcyc",   vc(0), 20);
    chk("t1_data",   vd(0), 64'h0706050403020100);
    chk("t1_nerr",   e_cyc.size(), 0);
    chk("t1_busy10", busy_at[10], 0);
    chk("t1_busy11", busy_at[11], 1);
    chk("t1_busy20", busy_at[20], 1);
    chk("t1_busy21", busy_at[21], 0);
    chk("t1_hold",   bus.rd_data, 64'h0706050403020100);
    chk("t1_busy47", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data",  bus.rd_data, 64'h0);
    chk("mid_rst_busy",  bus.busy, 0);
    chk("mid_rst_valid", bus.rd_valid, 0);
    repeat (2) tick();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) tick();
    chk("mid_rst_nvalid", v_cyc.size(), 1);
    chk("mid_rst_busy_end", bus.busy, 0);

    // seamless back-to-back
    start_test(6, 6, -1, 10, 14, 30);
    chk("b2b_nvalid", v_cyc.size(), 2);
    chk("b2b_v0",     vc(0), 20);
    chk("b2b_v1",     vc(1), 24);
    chk("b2b_d0",     vd(0), 64'h0706050403020100);
    chk("b2b_d1",     vd(1), 64'h0F0E0D0C0B0A0908);
    chk("b2b_nerr",   e_cyc.size(), 0);
    all_busy = 1'b1;
    for (int i = 11; i <= 24; i++) all_busy &= busy_at[i];
    chk("b2b_busy_span", all_busy, 1);
    chk("b2b_busy10", busy_at[10], 0);
    chk("b2b_busy25", busy_at[25], 0);

    // collision: second read dropped
    start_test(6, 6, -1, 10, 12, 30);
    chk("col_nvalid", v_cyc.size(), 1);
    chk("col_v0",     vc(0), 20);
    chk("col_d0",     vd(0), 64'h0706050403020100);
    chk("col_nerr",   e_cyc.size(), 1);
    chk("col_ecyc",   (e_cyc.size() > 0) ? e_cyc[0] : -1, 19);
    chk("col_busy20", busy_at[20], 1);
    chk("col_busy21", busy_at[21], 0);

    // latency frozen while busy, new value applies afterwards
    start_test(6, 9, 12, 10, 50, 70);
    chk("cfg_nvalid", v_cyc.size(), 2);
    chk("cfg_v0",     vc(0), 20);
    chk("cfg_v1",     vc(1), 63);
    chk("cfg_d1",     vd(1), 64'h5D5C5B5A59585756);

    // rl=0 behaves as rl=1; rl=31 at the top of the range
    start_test(0, 0, -1, 5, -1, 20);
    chk("rl0_v0", vc(0), 10);
    chk("rl0_d0", vd(0), 64'hF3F2F1F0EFEEEDEC);
    start_test(1, 1, -1, 5, -1, 20);
    chk("rl1_v0", vc(0), 10);
    chk("rl1_d0", vd(0), 64'hF3F2F1F0EFEEEDEC);
    start_test(31, 31, -1, 5, -1, 45);
    chk("rl31_nvalid", v_cyc.size(), 1);
    chk("rl31_v0", vc(0), 40);
    chk("rl31_d0", vd(0), 64'h2F2E2D2C2B2A2928);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
